// File: rtl/packetizer_pkg.sv
// Shared constants, flit field layout and FSM state type for the packetizer.
package packetizer_pkg;

  localparam int FLIT_W  = 48;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = DATA_W + 1;

  localparam logic [15:0] HEAD_MARK = 16'hAAAA;
  localparam logic [7:0]  BODY_TAG  = 8'h55;
  localparam logic [15:0] TAIL_MARK = 16'hFFFF;

  // Flit field bit ranges: marker | middle (dest/data) | low (seq/csum)
  localparam int MARK_HI = 47;
  localparam int MARK_LO = 32;
  localparam int MID_HI  = 31;
  localparam int MID_LO  = 16;
  localparam int LOW_HI  = 15;
  localparam int LOW_LO  = 0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BODY = 1'b1
  } state_e;

  // Assemble a flit from its three 16-bit fields.
  function automatic logic [FLIT_W-1:0] mk_flit(input logic [15:0] mark,
                                                input logic [15:0] mid,
                                                input logic [15:0] low);
    logic [FLIT_W-1:0] f;
    f = {FLIT_W{1'b0}};
    f[MARK_HI:MARK_LO] = mark;
    f[MID_HI:MID_LO]   = mid;
    f[LOW_HI:LOW_LO]   = low;
    return f;
  endfunction

endpackage

// File: rtl/packetizer_fifo.sv
// Show-ahead synchronous FIFO; rdata is valid whenever empty is low.
module pkt_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/packetizer.sv
// Packetizer: buffers 16-bit words and emits HEAD/BODY/TAIL 48-bit flits.
module packetizer
  import packetizer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  input  logic [7:0]        dest_id,
  output logic [FLIT_W-1:0] flitout
);

  state_e            state_q, state_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [7:0]        pkt_seq_q, pkt_seq_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic [15:0]       csum_q, csum_d;

  logic               fifo_full_s, fifo_empty_s, pop_s;
  logic [ENTRY_W-1:0] fifo_rdata_s;
  logic [15:0]        word_s, sum_s;
  logic               last_s;

  assign data_ready = !fifo_full_s;
  assign flitout    = flit_q;
  assign word_s     = fifo_rdata_s[DATA_W-1:0];
  assign last_s     = fifo_rdata_s[DATA_W];
  assign sum_s      = csum_q + word_s;

  pkt_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_valid),
    .pop     (pop_s),
    .wdata   ({data_last, data_in}),
    .rdata   (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Next-state, flit and counter computation; IDLE flit unless something is emitted.
  always_comb begin
    state_d    = state_q;
    flit_d     = {FLIT_W{1'b0}};
    pop_s      = 1'b0;
    pkt_seq_d  = pkt_seq_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          flit_d     = mk_flit(HEAD_MARK, {dest_id, 8'h00}, {8'h00, pkt_seq_q});
          csum_d     = 16'h0000;
          word_idx_d = 8'h00;
          state_d    = S_BODY;
        end else begin
          flit_d = {FLIT_W{1'b0}};
        end
      end
      S_BODY: begin
        if (!fifo_empty_s) begin
          pop_s  = 1'b1;
          csum_d = sum_s;
          if (last_s) begin
            flit_d    = mk_flit(TAIL_MARK, word_s, sum_s);
            pkt_seq_d = pkt_seq_q + 8'd1;
            state_d   = S_IDLE;
          end else begin
            flit_d     = mk_flit({BODY_TAG, word_idx_q}, word_s, sum_s);
            word_idx_d = word_idx_q + 8'd1;
          end
        end else begin
          flit_d = {FLIT_W{1'b0}};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, flit register and per-packet counters; reset discards any partial packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      flit_q     <= {FLIT_W{1'b0}};
      pkt_seq_q  <= 8'h00;
      word_idx_q <= 8'h00;
      csum_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      flit_q     <= flit_d;
      pkt_seq_q  <= pkt_seq_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: tb/tb_packetizer.sv
// Directed self-checking bench for the packetizer.
module tb_packetizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_last;
  logic        data_ready;
  logic [7:0]  dest_id;
  logic [47:0] flitout;

  int checks = 0;
  int errors = 0;

  packetizer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .dest_id    (dest_id),
    .flitout    (flitout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [15:0] d, input logic last);
    data_valid = 1'b1;
    data_in    = d;
    data_last  = last;
  endtask

  logic [47:0] got   [0:14];
  logic [47:0] exp_c [0:14];
  int          got_n;
  int          k;
  bit          gap;
  bit          ready_low;
  logic        rdy;

  initial begin
    reset_n    = 1'b0;
    data_in    = 16'h0000;
    data_valid = 1'b0;
    data_last  = 1'b0;
    dest_id    = 8'h12;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk48("idle_flit", flitout, 48'h0);
      chki("idle_ready", int'(data_ready), 1);
    end

    // 3-word packet
    put(16'h0001, 1'b0);
    tick();
    chk48("p1_pre", flitout, 48'h0);
    put(16'h0002, 1'b0);
    tick();
    chk48("p1_head", flitout, 48'hAAAA_1200_0000);
    put(16'h0003, 1'b1);
    tick();
    chk48("p1_body0", flitout, 48'h5500_0001_0001);
    data_valid = 1'b0;
    tick();
    chk48("p1_body1", flitout, 48'h5501_0002_0003);
    tick();
    chk48("p1_tail", flitout, 48'hFFFF_0003_0006);
    tick();
    chk48("p1_idle", flitout, 48'h0);

    // Single-word packet as second packet
    put(16'hFFFF, 1'b1);
    tick();
    chk48("p2_pre", flitout, 48'h0);
    data_valid = 1'b0;
    tick();
    chk48("p2_head", flitout, 48'hAAAA_1200_0001);
    tick();
    chk48("p2_tail", flitout, 48'hFFFF_FFFF_FFFF);
    tick();
    chk48("p2_idle", flitout, 48'h0);

    // Continuous input: three 4-word packets (seq 2,3,4), words 1..12
    exp_c = '{48'hAAAA_1200_0002, 48'h5500_0001_0001, 48'h5501_0002_0003,
              48'h5502_0003_0006, 48'hFFFF_0004_000A,
              48'hAAAA_1200_0003, 48'h5500_0005_0005, 48'h5501_0006_000B,
              48'h5502_0007_0012, 48'hFFFF_0008_001A,
              48'hAAAA_1200_0004, 48'h5500_0009_0009, 48'h5501_000A_0013,
              48'h5502_000B_001E, 48'hFFFF_000C_002A};
    got_n     = 0;
    k         = 0;
    gap       = 1'b0;
    ready_low = 1'b0;
    for (int cyc = 0; cyc < 40 && got_n < 15; cyc++) begin
      if (k < 12) put(16'(k + 1), (k % 4) == 3);
      else data_valid = 1'b0;
      rdy = data_ready;
      if (!rdy) ready_low = 1'b1;
      tick();
      if (data_valid && rdy) k++;
      if (flitout != 48'h0) begin
        got[got_n] = flitout;
        got_n++;
      end else if (got_n > 0) begin
        gap = 1'b1;
      end
    end
    data_valid = 1'b0;
    chki("cont_flit_count", got_n, 15);
    chki("cont_words_pushed", k, 12);
    chki("cont_no_gap", int'(gap), 0);
    chki("cont_ready_dropped", int'(ready_low), 1);
    for (int i = 0; i < 15; i++) begin
      if (i < got_n) chk48($sformatf("cont_flit%0d", i), got[i], exp_c[i]);
    end
    tick();
    chk48("cont_idle", flitout, 48'h0);
    tick();

    // Starvation mid-packet (seq 5): two bubbles between BODY flits
    put(16'h0010, 1'b0);
    tick();
    data_valid = 1'b0;
    tick();
    chk48("st_head", flitout, 48'hAAAA_1200_0005);
    tick();
    chk48("st_body0", flitout, 48'h5500_0010_0010);
    tick();
    chk48("st_bubble0", flitout, 48'h0);
    put(16'h0020, 1'b0);
    tick();
    chk48("st_bubble1", flitout, 48'h0);
    put(16'h0030, 1'b1);
    tick();
    chk48("st_body1", flitout, 48'h5501_0020_0030);
    data_valid = 1'b0;
    tick();
    chk48("st_tail", flitout, 48'hFFFF_0030_0060);
    tick();
    chk48("st_idle", flitout, 48'h0);

    // Reset mid-packet (seq 6), after the second BODY flit
    put(16'h0100, 1'b0);
    tick();
    put(16'h0200, 1'b0);
    tick();
    chk48("rs_head", flitout, 48'hAAAA_1200_0006);
    put(16'h0300, 1'b0);
    tick();
    chk48("rs_body0", flitout, 48'h5500_0100_0100);
    put(16'h0400, 1'b1);
    tick();
    chk48("rs_body1", flitout, 48'h5501_0200_0300);
    data_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk48("rs_flit_async", flitout, 48'h0);
    chki("rs_ready_async", int'(data_ready), 1);
    tick();
    reset_n = 1'b1;
    chk48("rs_flit_held", flitout, 48'h0);
    put(16'h0007, 1'b1);
    tick();
    chk48("rs_fifo_empty", flitout, 48'h0);
    data_valid = 1'b0;
    tick();
    chk48("rs_new_head", flitout, 48'hAAAA_1200_0000);
    tick();
    chk48("rs_new_tail", flitout, 48'hFFFF_0007_0007);
    tick();
    chk48("rs_idle", flitout, 48'h0);
    chki("rs_ready_end", int'(data_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
